inst_fetcher: RTL and testbench
===============================

// Module: inst_fetcher
// PURPOSE
//   Front-end fetch unit that drives the Decoder's fet_* interface. Keeps the PC, looks up a
//   direct-mapped instruction cache and refills it from the memory controller on a miss.
//   Predicts the next PC and issues at most one instruction per cycle unless downstream stalls.
//   Redirects to the ROB-supplied target on a misprediction clear.
// PARAMETERS
//   INDEX_BITS  6   log2 of icache line count (one 32-bit word per line)
//   RESET_PC    0   PC loaded at reset
// PORTS
//   clk_in              in   1   clock
//   rst_n_in            in   1   asynchronous, active-low reset
//   rdy_in              in   1   global enable; low = freeze all state
//   stall_in            in   1   downstream (RS/LSB/ROB) cannot accept an instruction next cycle
//   rob_clear_in        in   1   misprediction flush
//   rob_target_pc_in    in   32  correct PC when rob_clear_in is high
//   mc_request_out      out  1   instruction-word read request
//   mc_addr_out         out  32  word-aligned request address
//   mc_valid_in         in   1   1-cycle pulse: mc_inst_in is valid
//   mc_inst_in          in   32  returned instruction word
//   fet_issue_out       out  1   1-cycle pulse per issued instruction
//   fet_inst_out        out  32  instruction
//   fet_pc_out          out  32  its PC
//   fet_predict_pc_out  out  32  predicted next PC
// BEHAVIOUR
//   Reset (async, rst_n_in low): pc=RESET_PC; all valid bits=0; state=FETCH; every output=0.
//   rdy_in low: no state or output changes; fet_issue_out holds 0 after its current pulse.
//   Cache: index=pc[INDEX_BITS+1:2], tag=pc[31:INDEX_BITS+2]; hit = valid & tag match.
//   FETCH: hit & !stall_in -> next edge fet_issue_out=1 with inst/pc/predict; pc<=predict.
//     hit & stall_in -> fet_issue_out=0, pc held.
//     miss -> state MISS; mc_request_out=1, mc_addr_out=pc from the next cycle.
//   MISS: hold request until mc_valid_in; then fill line, mc_request_out=0, state FETCH.
//     The refetch hits one cycle later. Miss penalty = memory latency + 2 cycles.
//   Back-to-back hits issue on consecutive cycles; fet_issue_out never stays high over a stall.
//   Clear (rob_clear_in=1, highest priority): pc<=rob_target_pc_in; fet_issue_out=0 next cycle.
//     Clear in FETCH -> stay in FETCH.
//     Clear in MISS without mc_valid_in -> state FLUSH_WAIT; request held until mc_valid_in.
//     FLUSH_WAIT + mc_valid_in -> fill line (valid data for the old address); state FETCH at new pc.
//     Clear and mc_valid_in in the same cycle -> fill, then state FETCH at the new pc.
//   Prediction: sign-extended imm, 32-bit wrap-around add.
//     JAL (1101111)    -> pc+immJ
//     BRANCH (1100011) -> pc+immB if inst[31]=1 (backward), else pc+4
//     all other opcodes, including JALR -> pc+4
//   fet_* outputs are registered; they hold their last values while fet_issue_out=0.
// CONFIGURATION
//   STATIC_PREDICT_EN defined: the JAL/backward-branch prediction above is used.
//   STATIC_PREDICT_EN undefined: predict is always pc+4; JAL is redirected by rob_clear_in.
// TESTING
//   1. Reset, rdy_in=1 -> mc_request_out=1, mc_addr_out=0x0; mc returns 0x00000013 ->
//      fet_issue_out pulse, fet_pc_out=0x0, fet_predict_pc_out=0x4.
//   2. Words 0x0..0xC preloaded (hits) -> four consecutive issue pulses, PCs 0x0,0x4,0x8,0xC.
//   3. pc=0x10, inst 0x0080006F (jal x0,8) -> fet_predict_pc_out=0x18 (0x14 when macro undefined).
//      pc=0x20, inst 0xFE000CE3 (beq -8) -> fet_predict_pc_out=0x18.
//   4. stall_in=1 for 3 cycles during a hit stream -> no pulses, pc held;
//      release -> issue resumes at the same pc.
//   5. rob_clear_in=1, target 0x100, during MISS at 0x40 -> request held until mc_valid_in.
//      Line 0x40 filled, no issue for 0x40; next request at 0x100.
//   6. rob_clear_in coincident with a hit -> no issue next cycle; following fetch at the target.

Source files
------------

// File: rtl/inst_fetcher_if.sv
// Memory-controller and decoder-facing signal bundle of the instruction fetcher.
// master = fetch unit side, slave = memory controller / decoder side.
interface inst_fetcher_if;
    logic        mc_request_out;
    logic [31:0] mc_addr_out;
    logic        mc_valid_in;
    logic [31:0] mc_inst_in;
    logic        fet_issue_out;
    logic [31:0] fet_inst_out;
    logic [31:0] fet_pc_out;
    logic [31:0] fet_predict_pc_out;

    modport master (
        output mc_request_out, mc_addr_out,
        output fet_issue_out, fet_inst_out, fet_pc_out, fet_predict_pc_out,
        input  mc_valid_in, mc_inst_in
    );

    modport slave (
        input  mc_request_out, mc_addr_out,
        input  fet_issue_out, fet_inst_out, fet_pc_out, fet_predict_pc_out,
        output mc_valid_in, mc_inst_in
    );
endinterface

// File: rtl/inst_fetcher.sv
// Fetch unit: PC, direct-mapped one-word-per-line icache with miss refill, next-PC prediction.
// Optional macro STATIC_PREDICT_EN enables JAL / backward-branch prediction (else always pc+4).
module inst_fetcher #(
    parameter int          INDEX_BITS = 6,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    input  logic           rdy_in,
    input  logic           stall_in,
    input  logic           rob_clear_in,
    input  logic [31:0]    rob_target_pc_in,
    inst_fetcher_if.master bus
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [1:0] {
        ST_FETCH      = 2'd0,
        ST_MISS       = 2'd1,
        ST_FLUSH_WAIT = 2'd2
    } state_t;

    state_t                r_state;
    logic [31:0]           r_pc;
    logic [LINES-1:0]      r_valid;
    logic [TAG_BITS-1:0]   r_tag  [0:LINES-1];
    logic [31:0]           r_data [0:LINES-1];
    logic                  r_req;
    logic [31:0]           r_mc_addr;
    logic                  r_issue;
    logic [31:0]           r_fet_inst;
    logic [31:0]           r_fet_pc;
    logic [31:0]           r_fet_pred;

    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_hit;
    logic [31:0]           w_inst;
    logic [31:0]           w_predict;
    logic [INDEX_BITS-1:0] w_fill_index;
    logic [TAG_BITS-1:0]   w_fill_tag;
    logic                  w_fill;

    assign w_index      = r_pc[INDEX_BITS+1:2];
    assign w_tag        = r_pc[31:INDEX_BITS+2];
    assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_inst       = r_data[w_index];
    // The refill always targets the requested address, which survives a redirect of r_pc.
    assign w_fill_index = r_mc_addr[INDEX_BITS+1:2];
    assign w_fill_tag   = r_mc_addr[31:INDEX_BITS+2];
    assign w_fill       = rdy_in && (r_state != ST_FETCH) && bus.mc_valid_in;

`ifdef STATIC_PREDICT_EN
    function automatic logic [31:0] predict_pc(input logic [31:0] pc, input logic [31:0] inst);
        logic [31:0] imm_j;
        logic [31:0] imm_b;
        logic [31:0] next_pc;
        imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        case (inst[6:0])
            7'b1101111: next_pc = pc + imm_j;
            7'b1100011: next_pc = inst[31] ? (pc + imm_b) : (pc + 32'd4);
            default:    next_pc = pc + 32'd4;
        endcase
        return next_pc;
    endfunction

    assign w_predict = predict_pc(r_pc, w_inst);
`else
    assign w_predict = r_pc + 32'd4;
`endif

    // Line storage needs no reset: every read is qualified by r_valid.
    always_ff @(posedge clk_in) begin
        if (w_fill) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= bus.mc_inst_in;
        end
    end

    // Fetch FSM with PC, valid bits and every registered output.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_PC;
            r_valid    <= '0;
            r_req      <= 1'b0;
            r_mc_addr  <= 32'h0000_0000;
            r_issue    <= 1'b0;
            r_fet_inst <= 32'h0000_0000;
            r_fet_pc   <= 32'h0000_0000;
            r_fet_pred <= 32'h0000_0000;
        end else if (!rdy_in) begin
            r_issue <= 1'b0;
        end else begin
            r_issue <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (rob_clear_in) begin
                        r_pc <= rob_target_pc_in;
                    end else if (w_hit) begin
                        if (!stall_in) begin
                            r_issue    <= 1'b1;
                            r_fet_inst <= w_inst;
                            r_fet_pc   <= r_pc;
                            r_fet_pred <= w_predict;
                            r_pc       <= w_predict;
                        end
                    end else begin
                        r_state   <= ST_MISS;
                        r_req     <= 1'b1;
                        r_mc_addr <= r_pc;
                    end
                end
                ST_MISS, ST_FLUSH_WAIT: begin
                    // A clear cannot cancel an outstanding read; the line is still filled.
                    if (bus.mc_valid_in) begin
                        r_valid[w_fill_index] <= 1'b1;
                        r_req                 <= 1'b0;
                        r_state               <= ST_FETCH;
                    end else if (rob_clear_in) begin
                        r_state <= ST_FLUSH_WAIT;
                    end
                    if (rob_clear_in) begin
                        r_pc <= rob_target_pc_in;
                    end
                end
                default: begin
                    r_state <= ST_FETCH;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mc_request_out     = r_req;
    assign bus.mc_addr_out        = r_mc_addr;
    assign bus.fet_issue_out      = r_issue;
    assign bus.fet_inst_out       = r_fet_inst;
    assign bus.fet_pc_out         = r_fet_pc;
    assign bus.fet_predict_pc_out = r_fet_pred;
endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: directed vector table and corner sequences, then randomized traffic
// checked against a program-order reference (expected PC stream from the prediction rules).
`timescale 1ns/1ps
module tb_inst_fetcher;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b0;
    logic        stall = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] tgt = 32'h0;

    inst_fetcher_if bus ();

    inst_fetcher #(.INDEX_BITS(6), .RESET_PC(32'h0000_0000)) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .rdy_in           (rdy),
        .stall_in         (stall),
        .rob_clear_in     (clr),
        .rob_target_pc_in (tgt),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int issues = 0;
    int cyc = 0;
    int mem_lat = 1;
    logic [31:0] exp_pc = 32'h0;
    logic        prev_req = 1'b0;

    logic [31:0] dmem [logic [31:0]];
    logic [31:0] fb [16];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pred;
    } vec_t;
    vec_t vecs [6];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (dmem.exists(a)) return dmem[a];
        return fb[a[5:2]];
    endfunction

    // Reference prediction: decode the immediate as a signed integer offset.
    function automatic logic [31:0] ref_pred(input logic [31:0] pc, input logic [31:0] inst);
`ifdef STATIC_PREDICT_EN
        int off;
        if (inst[6:0] == 7'b1101111) begin
            off = int'({inst[19:12], inst[20], inst[30:21], 1'b0});
            if (inst[31]) off = off - (1 << 20);
            return pc + off;
        end
        if (inst[6:0] == 7'b1100011 && inst[31]) begin
            off = int'({inst[7], inst[30:25], inst[11:8], 1'b0}) - 4096;
            return pc + off;
        end
`endif
        return pc + 32'd4 + (inst & 32'd0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory controller model: waits mem_lat idle cycles, then a one-cycle valid pulse.
    initial begin
        int lat_cnt;
        lat_cnt = 0;
        bus.mc_valid_in = 1'b0;
        bus.mc_inst_in  = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.mc_valid_in) begin
                bus.mc_valid_in = 1'b0;
                lat_cnt = 0;
            end else if (bus.mc_request_out && rst_n) begin
                if (lat_cnt >= mem_lat) begin
                    bus.mc_valid_in = 1'b1;
                    bus.mc_inst_in  = mem_word(bus.mc_addr_out);
                    lat_cnt = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // One clock: sample the inputs seen at the edge, then score the outputs.
    task automatic cycle();
        logic        e_rdy, e_stall, e_clr;
        logic [31:0] e_tgt;
        @(posedge clk);
        e_rdy = rdy; e_stall = stall; e_clr = clr; e_tgt = tgt;
        #1;
        cyc++;
        if (bus.fet_issue_out) begin
            issues++;
            chk("issue_pc", bus.fet_pc_out, exp_pc);
            chk("issue_inst", bus.fet_inst_out, mem_word(exp_pc));
            chk("issue_pred", bus.fet_predict_pc_out, ref_pred(exp_pc, mem_word(exp_pc)));
            exp_pc = ref_pred(exp_pc, mem_word(exp_pc));
        end
        if (!e_rdy || e_stall || e_clr)
            chk("no_issue", {31'd0, bus.fet_issue_out}, 32'd0);
        if (e_rdy && e_clr) exp_pc = e_tgt;
        if (bus.mc_request_out && !prev_req)
            chk("req_addr", bus.mc_addr_out, exp_pc);
        prev_req = bus.mc_request_out;
    endtask

    task automatic wait_issue(input int bound);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            cycle();
            if (bus.fet_issue_out) begin
                ok = 1'b1;
                break;
            end
        end
        chk("issue_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic redirect(input logic [31:0] t);
        clr = 1'b1; tgt = t;
        cycle();
        clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_cyc;
        int rand_issues;
        fb = '{32'h00000013, 32'h00100093, 32'h0080006F, 32'h00000013,
               32'hFE000CE3, 32'h00208113, 32'h00001863, 32'h00000013,
               32'hFF1FF06F, 32'h00008067, 32'h00000013, 32'h00310193,
               32'h0080006F, 32'hFE000CE3, 32'h00000013, 32'h00420213};
`ifdef STATIC_PREDICT_EN
        vecs[0] = '{32'h00000010, 32'h0080006F, 32'h00000018};
        vecs[1] = '{32'h00000020, 32'hFE000CE3, 32'h00000018};
        vecs[4] = '{32'hFFFFFFFC, 32'h0080006F, 32'h00000004};
        vecs[5] = '{32'h00000060, 32'hFF1FF06F, 32'h00000050};
`else
        vecs[0] = '{32'h00000010, 32'h0080006F, 32'h00000014};
        vecs[1] = '{32'h00000020, 32'hFE000CE3, 32'h00000024};
        vecs[4] = '{32'hFFFFFFFC, 32'h0080006F, 32'h00000000};
        vecs[5] = '{32'h00000060, 32'hFF1FF06F, 32'h00000064};
`endif
        vecs[2] = '{32'h00000030, 32'h00001863, 32'h00000034};
        vecs[3] = '{32'h00000050, 32'h00008067, 32'h00000054};
        for (int i = 0; i < 6; i++) dmem[vecs[i].pc] = vecs[i].inst;
        for (int i = 0; i < 4; i++) dmem[32'(i * 4)] = 32'h00000013;
        dmem[32'h40]  = 32'h00100093;
        dmem[32'h100] = 32'h00000013;

        // Reset state
        #12;
        chk("rst_issue", {31'd0, bus.fet_issue_out}, 32'd0);
        chk("rst_req", {31'd0, bus.mc_request_out}, 32'd0);
        chk("rst_addr", bus.mc_addr_out, 32'h0);
        chk("rst_inst", bus.fet_inst_out, 32'h0);
        chk("rst_pc", bus.fet_pc_out, 32'h0);
        chk("rst_pred", bus.fet_predict_pc_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rdy = 1'b1;

        // Cold miss at the reset PC, then the first issue
        req_cyc = -1;
        for (int i = 0; i < 10 && req_cyc < 0; i++) begin
            cycle();
            if (bus.mc_request_out) req_cyc = cyc;
        end
        chk("t1_req_addr", bus.mc_addr_out, 32'h0);
        wait_issue(20);
        chk("t1_pc", bus.fet_pc_out, 32'h0);
        chk("t1_inst", bus.fet_inst_out, 32'h00000013);
        chk("t1_pred", bus.fet_predict_pc_out, 32'h4);
        chk("t1_penalty", 32'(cyc - req_cyc), 32'(mem_lat + 2));

        // Fill 0x0..0xC, then re-run them as back-to-back hits
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (bus.fet_issue_out && bus.fet_pc_out == 32'hC) break;
        end
        redirect(32'h0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t2_issue", {31'd0, bus.fet_issue_out}, 32'd1);
            chk("t2_pc", bus.fet_pc_out, 32'(k * 4));
        end

        // Prediction table
        for (int i = 0; i < 6; i++) begin
            redirect(vecs[i].pc);
            wait_issue(60);
            chk("vec_pc", bus.fet_pc_out, vecs[i].pc);
            chk("vec_inst", bus.fet_inst_out, vecs[i].inst);
            chk("vec_pred", bus.fet_predict_pc_out, vecs[i].pred);
        end

        // Stall during a hit stream
        redirect(32'h0);
        wait_issue(60);
        chk("t4_first", bus.fet_pc_out, 32'h0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t4_stalled", {31'd0, bus.fet_issue_out}, 32'd0);
        end
        stall = 1'b0;
        cycle();
        chk("t4_resume", {31'd0, bus.fet_issue_out}, 32'd1);
        chk("t4_resume_pc", bus.fet_pc_out, 32'h4);

        // Clear while a miss is outstanding
        mem_lat = 5;
        redirect(32'h40);
        for (int i = 0; i < 60; i++) begin
            if (bus.mc_request_out && bus.mc_addr_out == 32'h40) break;
            cycle();
        end
        chk("t5_miss_addr", bus.mc_addr_out, 32'h40);
        redirect(32'h100);
        for (int i = 0; i < 20; i++) begin
            if (!bus.mc_request_out) break;
            chk("t5_held_addr", bus.mc_addr_out, 32'h40);
            chk("t5_no_issue", {31'd0, bus.fet_issue_out}, 32'd0);
            cycle();
        end
        chk("t5_req_drop", {31'd0, bus.mc_request_out}, 32'd0);
        wait_issue(40);
        chk("t5_new_pc", bus.fet_pc_out, 32'h100);
        redirect(32'h40);
        cycle();
        chk("t5_filled_hit", {31'd0, bus.fet_issue_out}, 32'd1);
        chk("t5_filled_pc", bus.fet_pc_out, 32'h40);
        chk("t5_no_req", {31'd0, bus.mc_request_out}, 32'd0);

        // Clear coincident with a hit
        mem_lat = 1;
        redirect(32'h0);
        wait_issue(60);
        redirect(32'h8);
        chk("t6_no_issue", {31'd0, bus.fet_issue_out}, 32'd0);
        cycle();
        chk("t6_issue", {31'd0, bus.fet_issue_out}, 32'd1);
        chk("t6_pc", bus.fet_pc_out, 32'h8);

        // Randomized traffic
        rand_issues = issues;
        for (int i = 0; i < 3000; i++) begin
            rdy   = ($urandom_range(0, 9) != 0);
            stall = ($urandom_range(0, 4) == 0);
            clr   = ($urandom_range(0, 29) == 0);
            tgt   = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 255)) << 2);
            if (!bus.mc_request_out) mem_lat = $urandom_range(0, 3);
            cycle();
        end
        clr = 1'b0; stall = 1'b0; rdy = 1'b1;
        chk("liveness", {31'd0, (issues - rand_issues) > 100}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
